// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: samples the asynchronous Game Boy LCD bus and emits raster-ordered framebuffer writes.
module gb_lcd_capture #(
  parameter int H_PIXELS    = 160,
  parameter int V_PIXELS    = 144,
  parameter int ADDR_WIDTH  = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic                  gb_clk,
  input  logic                  gb_hsync,
  input  logic                  gb_vsync,
  input  logic [1:0]            gb_data,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [1:0]            fb_din,
  output logic                  fb_we,
  output logic                  frame_done,
  output logic                  locked,
  output logic                  overrun
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_PIXELS + 1);
  localparam logic [XW-1:0] X_END = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_END = YW'(V_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] cur, prv;
  logic ev_pix, ev_hs, ev_vs;
  logic [1:0] ev_data;
  logic [XW-1:0] x, x_v, x_n;
  logic [YW-1:0] y, y_n;
  logic [ADDR_WIDTH-1:0] line_base, base_n, waddr_n;
  logic [1:0] din_n;
  logic act, hs, px, adv, pix_ok, overrun_n;
  // {clk, hsync, vsync, data} travel through one chain so data stays aligned with its clock
  always_ff @(posedge vga_clk) begin
    sync_q[0] <= {gb_clk, gb_hsync, gb_vsync, gb_data};
    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    cur <= sync_q[SYNC_STAGES-1];
    prv <= cur;
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ev_pix  <= 1'b0;
      ev_hs   <= 1'b0;
      ev_vs   <= 1'b0;
      ev_data <= '0;
    end else begin
      ev_pix  <= prv[4] & ~cur[4];
      ev_hs   <= ~prv[3] & cur[3];
      ev_vs   <= ~prv[2] & cur[2];
      ev_data <= cur[1:0];
    end
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      fb_waddr   <= '0;
      fb_din     <= '0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      line_base  <= base_n;
      fb_waddr   <= waddr_n;
      fb_din     <= din_n;
      fb_we      <= pix_ok;
      frame_done <= ev_vs & act;
      locked     <= locked | ev_vs;
      overrun    <= overrun_n;
    end
  end
  // vsync wins over hsync; the pixel then sees the already-updated x/y
  always_comb begin
    act       = state == ACTIVE;
    state_n   = ev_vs ? ACTIVE : state;
    hs        = ev_hs & act & ~ev_vs;
    px        = ev_pix & act;
    adv       = hs && y < Y_END;
    x_v       = (ev_vs || hs) ? '0 : x;
    y_n       = ev_vs ? '0 : adv ? y + 1'b1 : y;
    base_n    = ev_vs ? '0 : adv ? line_base + LINE_STEP : line_base;
    pix_ok    = px && x_v < X_END && y_n < Y_END;
    x_n       = pix_ok ? x_v + 1'b1 : x_v;
    waddr_n   = pix_ok ? base_n + ADDR_WIDTH'(x_v) : fb_waddr;
    din_n     = pix_ok ? ev_data : fb_din;
    overrun_n = overrun | (hs && !adv) | (px && !pix_ok);
  end
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture: drives LCD bus events against a raster scoreboard model of gb_lcd_capture.
`timescale 1ns/1ps
module tb_gb_lcd_capture;
  localparam int H = 16, V = 12, AW = 8, SS = 2;
  logic vga_clk = 0, reset = 1, gb_clk = 1, gb_hsync = 0, gb_vsync = 0;
  logic [1:0] gb_data = 0;
  logic [AW-1:0] fb_waddr;
  logic [1:0] fb_din;
  logic fb_we, frame_done, locked, overrun;

  gb_lcd_capture #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .vga_clk(vga_clk), .reset(reset), .gb_clk(gb_clk), .gb_hsync(gb_hsync),
    .gb_vsync(gb_vsync), .gb_data(gb_data), .fb_waddr(fb_waddr), .fb_din(fb_din),
    .fb_we(fb_we), .frame_done(frame_done), .locked(locked), .overrun(overrun));

  always #20 vga_clk = ~vga_clk;

  int errs = 0, checks = 0;
  int n_we = 0, n_fd = 0, last_addr = 0, last_din = 0;
  int m_x = 0, m_y = 0, m_fd = 0;
  bit m_locked = 0, m_ov = 0;
  int exp_q[$];

  typedef struct {bit v; bit h; bit p; int d; bit we; int addr; int din; bit fd;} vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: raster position in plain integers, expected writes queued as addr*4+shade
  function automatic void model(input bit v, input bit h, input bit p, input int d);
    if (!m_locked) begin
      if (v) begin m_locked = 1; m_x = 0; m_y = 0; end
      return;
    end
    if (v) begin m_x = 0; m_y = 0; m_fd++; end
    else if (h) begin m_x = 0; if (m_y < V) m_y++; else m_ov = 1; end
    if (p) begin
      if (m_x < H && m_y < V) begin exp_q.push_back((m_y * H + m_x) * 4 + d); m_x++; end
      else m_ov = 1;
    end
  endfunction

  always @(negedge vga_clk) begin
    int e;
    if (fb_we) begin
      n_we++;
      last_addr = int'(fb_waddr);
      last_din = int'(fb_din);
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: got addr=%0d din=%0d expected no write", last_addr, last_din);
      end else begin
        e = exp_q.pop_front();
        if (last_addr * 4 + last_din != e) begin
          errs++;
          $display("FAIL write: got addr=%0d din=%0d expected addr=%0d din=%0d", last_addr, last_din, e / 4, e % 4);
        end
      end
    end
    if (frame_done) n_fd++;
  end

  task automatic ev(input bit v, input bit h, input bit p, input int d);
    model(v, h, p, d);
    @(negedge vga_clk);
    gb_data = 2'(d);
    repeat (3) @(negedge vga_clk);
    gb_clk = ~p;
    gb_hsync = h;
    gb_vsync = v;
    repeat (3) @(negedge vga_clk);
    gb_clk = 1;
    gb_hsync = 0;
    gb_vsync = 0;
  endtask

  task automatic settle();
    repeat (8) @(negedge vga_clk);
  endtask

  task automatic frame_lines();
    for (int y = 0; y < V; y++) begin
      if (y > 0) ev(0, 1, 0, 0);
      for (int x = 0; x < H; x++) ev(0, 0, 1, (x + y) & 3);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_waddr"}, int'(fb_waddr), 0);
    chk({tag, "_din"}, int'(fb_din), 0);
    chk({tag, "_we"}, int'(fb_we), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    chk({tag, "_frame_done_count"}, n_fd, m_fd);
    chk({tag, "_overrun"}, int'(overrun), int'(m_ov));
    chk({tag, "_locked"}, int'(locked), int'(m_locked));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w0, f0;
    tbl[0]  = '{0, 0, 1, 1, 1, 0,  1, 0};
    tbl[1]  = '{0, 0, 1, 2, 1, 1,  2, 0};
    tbl[2]  = '{0, 1, 1, 3, 1, 16, 3, 0};
    tbl[3]  = '{0, 0, 1, 0, 1, 17, 0, 0};
    tbl[4]  = '{1, 0, 1, 2, 1, 0,  2, 1};
    tbl[5]  = '{1, 1, 1, 1, 1, 0,  1, 1};
    tbl[6]  = '{0, 0, 1, 3, 1, 1,  3, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0,  0, 0};
    tbl[8]  = '{0, 0, 1, 2, 1, 16, 2, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0,  0, 1};
    tbl[10] = '{0, 0, 1, 1, 1, 0,  1, 0};

    repeat (4) @(negedge vga_clk);
    chk_reset_outputs("reset");
    reset = 0;

    w0 = n_we;
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 49) ev(0, 1, 0, 0);
      ev(0, 0, 1, i & 3);
    end
    settle();
    chk("prelock_writes", n_we - w0, 0);
    chk("prelock_locked", int'(locked), 0);
    chk("prelock_overrun", int'(overrun), 0);

    ev(1, 0, 0, 0);
    settle();
    chk("lock_locked", int'(locked), 1);
    chk("lock_no_frame_done", n_fd, 0);

    model(0, 0, 1, 3);
    @(negedge vga_clk);
    gb_data = 3;
    repeat (3) @(negedge vga_clk);
    gb_clk = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge vga_clk);
      chk("latency_we", int'(fb_we), int'(k == SS + 3));
      if (k == SS + 3) chk("latency_addr", int'(fb_waddr), 0);
      if (k == 3) gb_clk = 1;
    end
    model(1, 0, 0, 0);
    @(negedge vga_clk);
    gb_vsync = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge vga_clk);
      chk("latency_frame_done", int'(frame_done), int'(k == SS + 3));
      if (k == 3) gb_vsync = 0;
    end
    settle();

    foreach (tbl[i]) begin
      w0 = n_we;
      f0 = n_fd;
      ev(tbl[i].v, tbl[i].h, tbl[i].p, tbl[i].d);
      repeat (4) @(negedge vga_clk);
      chk($sformatf("vec%0d_we", i), n_we - w0, int'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), last_addr, tbl[i].addr);
        chk($sformatf("vec%0d_din", i), last_din, tbl[i].din);
      end
      chk($sformatf("vec%0d_frame_done", i), n_fd - f0, int'(tbl[i].fd));
    end

    ev(1, 0, 0, 0);
    settle();
    f0 = n_fd;
    w0 = n_we;
    frame_lines();
    settle();
    chk("frame_writes", n_we - w0, H * V);
    chk("frame_last_addr", last_addr, H * V - 1);
    chk("frame_overrun", int'(overrun), 0);
    chk("frame_no_early_done", n_fd - f0, 0);
    ev(1, 0, 0, 0);
    settle();
    chk("frame_done_once", n_fd - f0, 1);

    w0 = n_we;
    for (int i = 0; i < H + 5; i++) ev(0, 0, 1, i & 3);
    settle();
    chk("long_line_writes", n_we - w0, H);
    chk("long_line_last_addr", last_addr, H - 1);
    chk("long_line_overrun", int'(overrun), 1);
    ev(1, 0, 0, 0);
    frame_lines();
    settle();
    chk("overrun_sticky", int'(overrun), 1);
    w0 = n_we;
    ev(0, 1, 0, 0);
    for (int i = 0; i < H; i++) ev(0, 0, 1, i & 3);
    settle();
    chk("extra_line_writes", n_we - w0, 0);

    ev(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      ev(r < 4, r >= 4 && r < 14, $urandom_range(0, 9) > 1, int'($urandom_range(0, 3)));
    end
    settle();
    chk_model("random");

    ev(1, 0, 0, 0);
    for (int y = 0; y < 5; y++) begin
      if (y > 0) ev(0, 1, 0, 0);
      for (int x = 0; x < H; x++) ev(0, 0, 1, 1);
    end
    ev(0, 1, 0, 0);
    for (int x = 0; x < 8; x++) ev(0, 0, 1, 2);
    settle();
    @(negedge vga_clk);
    reset = 1;
    @(negedge vga_clk);
    reset = 0;
    m_locked = 0;
    m_ov = 0;
    m_x = 0;
    m_y = 0;
    chk_reset_outputs("midreset");
    w0 = n_we;
    for (int i = 0; i < 10; i++) ev(0, 0, 1, 3);
    ev(0, 1, 0, 0);
    settle();
    chk("midreset_ignored", n_we - w0, 0);
    ev(1, 0, 0, 0);
    ev(0, 0, 1, 2);
    settle();
    chk("midreset_resume_writes", n_we - w0, 1);
    chk("midreset_resume_addr", last_addr, 0);
    chk("midreset_resume_din", last_din, 2);
    chk_model("final");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
